// File: rtl/chip_select_arbiter.sv
// Round-robin owner arbiter for a shared 3-to-8 chip-select decoder, one dead cycle between owners.
// Define CSARB_TIMEOUT_EN to build the hold counter that force-revokes a grant after HOLD_MAX cycles.
module chip_select_arbiter #(
  parameter int unsigned HOLD_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [2:0] sel,
  output logic [7:0] gnt,
  output logic       valid,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [2:0] ptr, ptr_nxt, sel_nxt, pick, cand;
  logic [7:0] gnt_nxt;
  logic       valid_nxt, found, release_now, expire;

  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_hold_range
    $error("chip_select_arbiter: HOLD_MAX must lie in 1..255");
  end

  // First requester at or after ptr, wrapping 7 -> 0.
  always_comb begin
    found = 1'b0;
    pick  = ptr;
    cand  = ptr;
    for (int k = 0; k < 8; k++) begin
      cand = ptr + 3'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign release_now = done || !req[sel];

`ifdef CSARB_TIMEOUT_EN
  logic [7:0] hold_cnt;
  logic       timeout_nxt;

  // hold_cnt counts completed grant cycles, so the HOLD_MAX-th cycle is the last one.
  assign expire      = (state == GRANT) && (hold_cnt == 8'(HOLD_MAX - 1));
  assign timeout_nxt = expire && !release_now;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= 8'd0;
      timeout  <= 1'b0;
    end else begin
      hold_cnt <= (state == GRANT) ? hold_cnt + 8'd1 : 8'd0;
      timeout  <= timeout_nxt;
    end
  end
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt = state;
    ptr_nxt   = ptr;
    sel_nxt   = sel;
    gnt_nxt   = gnt;
    valid_nxt = valid;
    unique case (state)
      IDLE, GAP: begin
        if (found) begin
          state_nxt = GRANT;
          sel_nxt   = pick;
          gnt_nxt   = 8'b1 << pick;
          valid_nxt = 1'b1;
        end else begin
          state_nxt = IDLE;
          gnt_nxt   = 8'h00;
          valid_nxt = 1'b0;
        end
      end
      GRANT: begin
        if (release_now || expire) begin
          state_nxt = GAP;
          gnt_nxt   = 8'h00;
          valid_nxt = 1'b0;
          ptr_nxt   = sel + 3'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = 8'h00;
        valid_nxt = 1'b0;
      end
    endcase
  end

  // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= 3'd0;
      sel   <= 3'd0;
      gnt   <= 8'h00;
      valid <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      sel   <= sel_nxt;
      gnt   <= gnt_nxt;
      valid <= valid_nxt;
    end
  end

endmodule

// File: doc/chip_select_arbiter.md
CHIP_SELECT_ARBITER -- requirements
Module: chip_select_arbiter

Interface
REQ-001 Parameter HOLD_MAX, default 15, maximum cycles a grant is held before forced revoke (range 1..255; used only with CSARB_TIMEOUT_EN).
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST_N  input  1  reset, asynchronous, active-low.
REQ-004 REQ  input  8  per-requester request; bit i = requester i; level-sensitive.
REQ-005 DONE  input  1  owner releases the shared decoder; sampled only in GRANT.
REQ-006 SEL  output  3  binary index of the current owner; drives the 3-to-8 decoder select input A.
REQ-007 GNT  output  8  one-hot grant; bit SEL set while VALID, else all zero.
REQ-008 VALID  output  1  high while a grant is active.
REQ-009 TIMEOUT  output  1  one-cycle pulse on forced revoke.

Function
REQ-010 FSM states SHALL be IDLE, GRANT, GAP; encoding is free.
REQ-011 IDLE: if REQ != 0, the block SHALL select the first set bit at or after pointer PTR, scanning upward and wrapping 7->0; it SHALL load SEL, set VALID and GNT, and enter GRANT on the next edge.
REQ-012 Grant latency SHALL be exactly 1 cycle: REQ sampled at edge N gives GNT valid after edge N+1.
REQ-013 IDLE with REQ == 0 SHALL remain in IDLE with VALID=0, GNT=0, and SEL holding its last value.
REQ-014 GRANT SHALL hold SEL, GNT and VALID stable while REQ[SEL]=1 and DONE=0.
REQ-015 GRANT: DONE=1 or REQ[SEL]=0 SHALL drop VALID and GNT on the next edge and enter GAP.
REQ-016 On leaving GRANT, PTR SHALL become SEL+1 mod 8; 7 wraps to 0.
REQ-017 GAP SHALL last exactly 1 cycle with GNT=0 and VALID=0 (decoder dead time), then arbitrate per REQ-011 on the same edge it exits, so back-to-back owners are separated by exactly one idle cycle.
REQ-018 DONE asserted outside GRANT SHALL be ignored.
REQ-019 Requests from the current owner SHALL never win two consecutive grants while another bit of REQ is set; round-robin fairness bounds wait time to 7 grants.
REQ-020 GNT SHALL be at most one-hot at every cycle; GNT SHALL equal decode(SEL) whenever VALID=1.
REQ-021 All outputs SHALL be registered; no combinational path from REQ or DONE to any output.

Reset
REQ-022 RST_N low SHALL immediately force state=IDLE, PTR=0, SEL=0, GNT=0, VALID=0, TIMEOUT=0, and hold-counter=0, regardless of CLK.
REQ-023 Reset asserted during GRANT SHALL revoke the grant with no GAP cycle; the first arbitration after release SHALL start from PTR=0.
REQ-024 Deassertion of RST_N SHALL take effect on the first rising CLK edge after release; no grant is issued before that edge.

Configuration
REQ-025 Macro CSARB_TIMEOUT_EN defined: an 8-bit hold counter SHALL clear on entry to GRANT and increment on each GRANT cycle.
REQ-026 With CSARB_TIMEOUT_EN defined, once the count reaches HOLD_MAX with DONE=0 and REQ[SEL]=1, the next edge SHALL revoke as in REQ-015 and pulse TIMEOUT for 1 cycle.
REQ-027 With CSARB_TIMEOUT_EN defined, DONE and timeout on the same cycle SHALL be treated as a normal release, with TIMEOUT=0.
REQ-028 Macro CSARB_TIMEOUT_EN undefined: no counter is built, TIMEOUT SHALL be tied 0, and grants are held indefinitely.

Verification
REQ-029 Reset case: RST_N=0, then REQ=8'h00 -> SEL=0, GNT=0, VALID=0 for all cycles.
REQ-030 Single requester: REQ=8'h08 at edge N -> SEL=3 and GNT=8'h08 after edge N+1; DONE pulse -> GNT=0 for 1 cycle and PTR=4.
REQ-031 Full contention: REQ=8'hFF held, DONE pulsed each grant -> grant order 0,1,...,7,0, with exactly one GAP cycle between grants.
REQ-032 Wrap case: PTR=7 and REQ=8'h81 -> requester 7 granted first, then requester 0.
REQ-033 Timeout (CSARB_TIMEOUT_EN, HOLD_MAX=4): REQ=8'h02 held, DONE=0 -> revoke after 4 GRANT cycles, TIMEOUT=1 for one cycle, GAP, then re-grant to requester 1.
REQ-034 Reset mid-grant: RST_N pulsed low while GNT=8'h20 -> GNT=0 asynchronously; REQ=8'hFF after release -> requester 0 granted first.
